// File: rtl/gumnut_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gumnut_pkg                                                    |
// | Purpose  : Shared Gumnut types: FSM states, decode masks, ALU fn codes.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package gumnut_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_IMMED   = 2'd0,
        CLS_SHIFT   = 2'd1,
        CLS_REG     = 2'd2,
        CLS_ILLEGAL = 2'd3
    } instr_class_t;

    localparam logic [17:0] c_immed_mask  = 18'h20000;
    localparam logic [17:0] c_immed_match = 18'h00000;
    localparam logic [17:0] c_shift_mask  = 18'h38000;
    localparam logic [17:0] c_shift_match = 18'h30000;
    localparam logic [17:0] c_reg_mask    = 18'h3C000;
    localparam logic [17:0] c_reg_match   = 18'h38000;

    localparam int c_rd_lsb = 11;
    localparam int c_rs_lsb = 8;
    localparam int c_r2_lsb = 5;

    localparam logic [2:0] c_alu_add  = 3'd0;
    localparam logic [2:0] c_alu_addc = 3'd1;
    localparam logic [2:0] c_alu_sub  = 3'd2;
    localparam logic [2:0] c_alu_subc = 3'd3;
    localparam logic [2:0] c_alu_and  = 3'd4;
    localparam logic [2:0] c_alu_or   = 3'd5;
    localparam logic [2:0] c_alu_xor  = 3'd6;
    localparam logic [2:0] c_alu_mask = 3'd7;

    localparam logic [1:0] c_shift_shl = 2'd0;
    localparam logic [1:0] c_shift_shr = 2'd1;
    localparam logic [1:0] c_shift_rol = 2'd2;
    localparam logic [1:0] c_shift_ror = 2'd3;

    function automatic instr_class_t decode_class(input logic [17:0] ir);
        if ((ir & c_immed_mask) == c_immed_match)      return CLS_IMMED;
        else if ((ir & c_shift_mask) == c_shift_match) return CLS_SHIFT;
        else if ((ir & c_reg_mask) == c_reg_match)     return CLS_REG;
        else                                           return CLS_ILLEGAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gumnut_alu_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gumnut_alu_sequencer_if                                       |
// | Purpose  : Instruction handshake plus the operand/result bus to the ALU. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface gumnut_alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int IR_W   = 18
) ();
    logic              instr_valid;
    logic [IR_W-1:0]   instr;
    logic              instr_ready;
    logic [DATA_W-1:0] alu_rs;
    logic [DATA_W-1:0] alu_r2;
    logic [IR_W-1:0]   alu_ir;
    logic              alu_cin;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_shift_result;
    logic              alu_c;

    // Master is the front end together with the external ALU.
    modport master (
        output instr_valid, instr, alu_result, alu_shift_result, alu_c,
        input  instr_ready, alu_rs, alu_r2, alu_ir, alu_cin
    );

    modport slave (
        input  instr_valid, instr, alu_result, alu_shift_result, alu_c,
        output instr_ready, alu_rs, alu_r2, alu_ir, alu_cin
    );
endinterface
`default_nettype wire

// File: rtl/gumnut_gpr_file.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gumnut_gpr_file                                               |
// | Purpose  : GPR file, two read ports, one write port muxing WB and debug. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module gumnut_gpr_file #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic [ADDR_W-1:0] rs_addr,
    input  wire logic [ADDR_W-1:0] r2_addr,
    output logic      [DATA_W-1:0] rs_data,
    output logic      [DATA_W-1:0] r2_data,
    input  wire logic              wb_we,
    input  wire logic [ADDR_W-1:0] wb_addr,
    input  wire logic [DATA_W-1:0] wb_data,
    input  wire logic              ext_we,
    input  wire logic [ADDR_W-1:0] ext_addr,
    input  wire logic [DATA_W-1:0] ext_data
);
    logic [DATA_W-1:0] w_gpr [NUM_REGS];
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    // The sequencer only raises ext_we in IDLE and wb_we in WB, so they never collide.
    assign w_we   = wb_we | ext_we;
    assign w_addr = ext_we ? ext_addr : wb_addr;
    assign w_data = ext_we ? ext_data : wb_data;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            if (gi == 0) begin : g_zero
                assign w_gpr[gi] = '0;
            end else begin : g_reg
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge clk) begin
                    if (!rst_n)
                        r_q <= '0;
                    else if (w_we && (w_addr == ADDR_W'(gi)))
                        r_q <= w_data;
                end
                assign w_gpr[gi] = r_q;
            end
        end
    endgenerate

    assign rs_data = w_gpr[rs_addr];
    assign r2_data = w_gpr[r2_addr];
endmodule
`default_nettype wire

// File: rtl/gumnut_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gumnut_alu_sequencer                                          |
// | Purpose  : IDLE/READ/EXEC/WB control for Gumnut ALU, shift and GPR ops.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module gumnut_alu_sequencer
    import gumnut_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int IR_W     = 18
) (
    input  wire logic                        clk,
    input  wire logic                        rst_n,
    gumnut_alu_sequencer_if.slave            bus,
    input  wire logic                        ext_we,
    input  wire logic [$clog2(NUM_REGS)-1:0] ext_addr,
    input  wire logic [DATA_W-1:0]           ext_data,
    output logic                             done,
    output logic                             illegal,
    output logic                             cc_z,
    output logic                             cc_c
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    state_t            r_state;
    logic              r_ready;
    logic [IR_W-1:0]   r_ir;
    logic [IR_W-1:0]   r_alu_ir;
    logic [DATA_W-1:0] r_alu_rs;
    logic [DATA_W-1:0] r_alu_r2;
    logic [DATA_W-1:0] r_res;
    logic              r_carry;
    logic              r_done;
    logic              r_illegal;
    logic              r_cc_z;
    logic              r_cc_c;

    instr_class_t      w_class;
    logic [ADDR_W-1:0] w_rd;
    logic [ADDR_W-1:0] w_rs;
    logic [ADDR_W-1:0] w_r2;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_r2_data;
    logic              w_wb_we;
    logic              w_ext_we;

    assign w_class  = decode_class(r_ir);
    assign w_rd     = r_ir[c_rd_lsb +: ADDR_W];
    assign w_rs     = r_ir[c_rs_lsb +: ADDR_W];
    assign w_r2     = r_ir[c_r2_lsb +: ADDR_W];
    assign w_wb_we  = (r_state == WB) && (w_class != CLS_ILLEGAL);
    assign w_ext_we = ext_we && (r_state == IDLE);

    gumnut_gpr_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_gpr (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (w_rs),
        .r2_addr  (w_r2),
        .rs_data  (w_rs_data),
        .r2_data  (w_r2_data),
        .wb_we    (w_wb_we),
        .wb_addr  (w_rd),
        .wb_data  (r_res),
        .ext_we   (w_ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data)
    );

    assign bus.instr_ready = r_ready;
    assign bus.alu_rs      = r_alu_rs;
    assign bus.alu_r2      = r_alu_r2;
    assign bus.alu_ir      = r_alu_ir;
    assign bus.alu_cin     = r_cc_c;
    assign done            = r_done;
    assign illegal         = r_illegal;
    assign cc_z            = r_cc_z;
    assign cc_c            = r_cc_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_ir      <= '0;
            r_alu_ir  <= '0;
            r_alu_rs  <= '0;
            r_alu_r2  <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_cc_z    <= 1'b0;
            r_cc_c    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.instr_valid && r_ready) begin
                        r_ir    <= bus.instr;
                        r_ready <= 1'b0;
                        r_state <= READ;
                    end
                end
                READ: begin
                    r_alu_rs <= w_rs_data;
                    r_alu_r2 <= w_r2_data;
                    r_alu_ir <= r_ir;
                    r_state  <= EXEC;
                end
                EXEC: begin
                    r_res     <= (w_class == CLS_SHIFT) ? bus.alu_shift_result : bus.alu_result;
                    r_carry   <= bus.alu_c;
                    r_done    <= 1'b1;
                    r_illegal <= (w_class == CLS_ILLEGAL);
                    r_state   <= WB;
                end
                WB: begin
                    // Illegal instructions leave the flags untouched as well as the GPRs.
                    if (w_class != CLS_ILLEGAL) begin
                        r_cc_z <= (r_res == '0);
                        r_cc_c <= r_carry;
                    end
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gumnut_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_gumnut_alu_sequencer                                       |
// | Purpose  : Directed and random instruction streams against a GPR model.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_gumnut_alu_sequencer;
    import gumnut_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ext_we;
    logic [2:0] ext_addr;
    logic [7:0] ext_data;
    logic       done, illegal, cc_z, cc_c;

    int n_vec = 0;
    int n_bad = 0;

    int m_gpr [8];
    bit m_z, m_c;

    int t_ar, t_ac, t_sr, t_sc;

    gumnut_alu_sequencer_if bus ();

    gumnut_alu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ext_we   (ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data),
        .done     (done),
        .illegal  (illegal),
        .cc_z     (cc_z),
        .cc_c     (cc_c)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic ALU behaviour, used both by the ALU stand-in and the model.
    function automatic void arith_op(input int fn, input int a, input int b, input int cin,
                                     output int r, output int c);
        int s;
        case (fn)
            0:       s = a + b;
            1:       s = a + b + cin;
            2:       s = a - b;
            3:       s = a - b - cin;
            4:       s = a & b;
            5:       s = a | b;
            6:       s = a ^ b;
            default: s = a & ~b;
        endcase
        r = s & 255;
        if (fn <= 1)      c = (s > 255) ? 1 : 0;
        else if (fn <= 3) c = (s < 0) ? 1 : 0;
        else              c = 0;
    endfunction

    function automatic void shift_op(input int fn, input int a, input int n,
                                     output int r, output int c);
        case (fn)
            0: begin r = (a << n) & 255;               c = (n == 0) ? 0 : (a >> (8 - n)) & 1; end
            1: begin r = a >> n;                       c = (n == 0) ? 0 : (a >> (n - 1)) & 1; end
            2: begin r = ((a << n) | (a >> (8 - n))) & 255; c = (n == 0) ? 0 : r & 1; end
            default: begin r = ((a >> n) | (a << (8 - n))) & 255; c = (n == 0) ? 0 : (r >> 7) & 1; end
        endcase
    endfunction

    // Combinational ALU stand-in driven from the sequencer's registered operands.
    always_comb begin
        arith_op(bus.alu_ir[17] ? int'(bus.alu_ir[2:0]) : int'(bus.alu_ir[16:14]),
                 int'(bus.alu_rs),
                 bus.alu_ir[17] ? int'(bus.alu_r2) : int'(bus.alu_ir[7:0]),
                 int'(bus.alu_cin), t_ar, t_ac);
        shift_op(int'(bus.alu_ir[1:0]), int'(bus.alu_rs), int'(bus.alu_ir[7:5]), t_sr, t_sc);
        bus.alu_result       = t_ar[7:0];
        bus.alu_shift_result = t_sr[7:0];
        bus.alu_c            = (bus.alu_ir[17:15] == 3'b110) ? t_sc[0] : t_ac[0];
    end

    function automatic logic [17:0] enc_reg(input logic [2:0] fn, input logic [2:0] rd,
                                            input logic [2:0] rs, input logic [2:0] r2);
        return {4'b1110, rd, rs, r2, 2'b00, fn};
    endfunction

    function automatic logic [17:0] enc_imm(input logic [2:0] fn, input logic [2:0] rd,
                                            input logic [2:0] rs, input logic [7:0] imm);
        return {1'b0, fn, rd, rs, imm};
    endfunction

    function automatic logic [17:0] enc_sh(input logic [1:0] fn, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [2:0] cnt);
        return {3'b110, 1'b0, rd, rs, cnt, 3'b000, fn};
    endfunction

    task automatic model_reset();
        foreach (m_gpr[i]) m_gpr[i] = 0;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    // Architectural effect of one instruction on the model state.
    task automatic model_step(input logic [17:0] ir, output bit ill);
        int rd, rs, r2, res, c;
        rd = int'(ir[13:11]);
        rs = int'(ir[10:8]);
        r2 = int'(ir[7:5]);
        ill = 1'b0;
        res = 0;
        c   = 0;
        if (!ir[17])                  arith_op(int'(ir[16:14]), m_gpr[rs], int'(ir[7:0]), int'(m_c), res, c);
        else if (ir[17:15] == 3'b110) shift_op(int'(ir[1:0]), m_gpr[rs], r2, res, c);
        else if (ir[17:14] == 4'b1110) arith_op(int'(ir[2:0]), m_gpr[rs], m_gpr[r2], int'(m_c), res, c);
        else                          ill = 1'b1;
        if (!ill) begin
            if (rd != 0) m_gpr[rd] = res;
            m_z = (res == 0);
            m_c = (c != 0);
        end
    endtask

    task automatic ext_write(input logic [2:0] a, input logic [7:0] d);
        ext_we = 1'b1; ext_addr = a; ext_data = d;
        if (a != 3'd0) m_gpr[a] = int'(d);
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    // Starts and ends at a falling edge with the DUT in IDLE.
    task automatic run_instr(input logic [17:0] ir, input bit ext_acc, input bit ext_rd,
                             input logic [2:0] ea, input logic [7:0] ed);
        int cnt;
        bit ill;
        cnt = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = ir;
        while (!bus.instr_ready && cnt < 16) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 16) check("accept_timeout", 32'(cnt), 32'd0);
        if (ext_acc) begin
            ext_we = 1'b1; ext_addr = ea; ext_data = ed;
            if (ea != 3'd0) m_gpr[ea] = int'(ed);
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        ext_we = 1'b0;
        if (ext_rd) begin
            ext_we = 1'b1; ext_addr = ea; ext_data = ed;
        end
        check("ready_in_read", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        ext_we = 1'b0;
        check("alu_rs", 32'(bus.alu_rs), 32'(m_gpr[ir[10:8]]));
        check("alu_r2", 32'(bus.alu_r2), 32'(m_gpr[ir[7:5]]));
        check("alu_ir", 32'(bus.alu_ir), 32'(ir));
        check("alu_cin", 32'(bus.alu_cin), 32'(m_c));
        check("done_early", 32'(done), 32'd0);
        model_step(ir, ill);
        @(negedge clk);
        check("done_wb", 32'(done), 32'd1);
        check("illegal_wb", 32'(illegal), 32'(ill));
        @(negedge clk);
        check("cc_z", 32'(cc_z), 32'(m_z));
        check("cc_c", 32'(cc_c), 32'(m_c));
        check("ready_idle", 32'(bus.instr_ready), 32'd1);
        check("done_clear", 32'(done), 32'd0);
    endtask

    task automatic run(input logic [17:0] ir);
        run_instr(ir, 1'b0, 1'b0, 3'd0, 8'd0);
    endtask

    initial begin
        logic [17:0] ir;
        bit          ill;
        int          k;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        ext_we = 1'b0; ext_addr = '0; ext_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'({cc_z, cc_c}), 32'd0);
        check("rst_alu", 32'({bus.alu_rs, bus.alu_r2, bus.alu_ir}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // add r3,r1,r2 with 0x0F + 0x01
        ext_write(3'd1, 8'h0F);
        ext_write(3'd2, 8'h01);
        run(enc_reg(c_alu_add, 3'd3, 3'd1, 3'd2));
        run(enc_reg(c_alu_or, 3'd0, 3'd3, 3'd3));

        // addi wraps to zero with carry, then addc consumes it
        ext_write(3'd1, 8'hFF);
        run(enc_imm(c_alu_add, 3'd4, 3'd1, 8'h01));
        run(enc_reg(c_alu_addc, 3'd5, 3'd0, 3'd0));
        run(enc_reg(c_alu_or, 3'd0, 3'd4, 3'd5));

        // shifts
        ext_write(3'd1, 8'h81);
        run(enc_sh(c_shift_shl, 3'd6, 3'd1, 3'd1));
        run(enc_sh(c_shift_ror, 3'd7, 3'd1, 3'd1));
        run(enc_reg(c_alu_or, 3'd0, 3'd6, 3'd7));

        // write to r0 is dropped, then an illegal class
        run(enc_imm(c_alu_add, 3'd0, 3'd1, 8'h10));
        run(enc_reg(c_alu_or, 3'd1, 3'd0, 3'd0));
        run(18'h3F000);
        run(enc_reg(c_alu_or, 3'd0, 3'd6, 3'd7));

        // back-to-back issue with valid held high
        bus.instr_valid = 1'b1;
        bus.instr = enc_imm(c_alu_add, 3'd1, 3'd1, 8'h01);
        for (int i = 0; i < 16; i++) begin
            check("ready_cadence", 32'(bus.instr_ready), 32'((i % 4) == 0));
            if ((i % 4) == 0) model_step(bus.instr, ill);
            @(negedge clk);
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        run(enc_reg(c_alu_or, 3'd0, 3'd1, 3'd0));

        // ext write during READ ignored, ext write with accept visible
        run_instr(enc_reg(c_alu_or, 3'd0, 3'd3, 3'd3), 1'b0, 1'b1, 3'd3, 8'hAA);
        run(enc_reg(c_alu_or, 3'd0, 3'd3, 3'd3));
        run_instr(enc_reg(c_alu_or, 3'd0, 3'd2, 3'd2), 1'b1, 1'b0, 3'd2, 8'h5A);

        // reset in EXEC abandons the instruction
        bus.instr_valid = 1'b1;
        bus.instr = enc_reg(c_alu_add, 3'd3, 3'd1, 3'd2);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(bus.instr_ready), 32'd1);
        check("abort_flags", 32'({cc_z, cc_c}), 32'd0);
        check("abort_alu_rs", 32'(bus.alu_rs), 32'd0);
        run(enc_reg(c_alu_or, 3'd0, 3'd1, 3'd2));
        run(enc_reg(c_alu_or, 3'd0, 3'd3, 3'd6));

        // random stream
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 3)      ir = enc_imm(3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
            else if (k <= 6) ir = enc_reg(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            else if (k <= 8) ir = enc_sh(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            else             ir = {4'b1111, 14'($urandom)};
            if ($urandom_range(0, 4) == 0) ext_write(3'($urandom), 8'($urandom));
            run_instr(ir, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      3'($urandom), 8'($urandom));
        end
        run(enc_reg(c_alu_or, 3'd0, 3'd1, 3'd2));
        run(enc_reg(c_alu_or, 3'd0, 3'd3, 3'd4));
        run(enc_reg(c_alu_or, 3'd0, 3'd5, 3'd6));
        run(enc_reg(c_alu_or, 3'd0, 3'd7, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
